// File: rtl/sim_clock_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sim_clock_scheduler_pkg
// Brief    : Shared state encoding and phase clamp for the clock scheduler.
// Revision : 1.0
// ============================================================================
package sim_clock_scheduler_pkg;

    localparam int c_DIV_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ALIGN = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    // The first strobe can never be later than one full period after RUN entry.
    function automatic logic [31:0] clamp_phase(input logic [31:0] phase,
                                                input logic [31:0] div);
        if (div == 32'd0) begin
            return 32'd0;
        end
        return (phase < (div - 32'd1)) ? phase : (div - 32'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sim_clock_sched_chan.sv
`default_nettype none
// ============================================================================
// Module   : sim_clock_sched_chan
// Brief    : One clock-enable channel: divisor, phase, down-counter, active.
// Revision : 1.0
// ============================================================================
module sim_clock_sched_chan
    import sim_clock_scheduler_pkg::*;
#(
    parameter int DIV_W = c_DIV_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_cfg_we,
    input  logic [DIV_W-1:0] i_cfg_div,
    input  logic [DIV_W-1:0] i_cfg_phase,
    input  logic             i_load,
    input  logic             i_run,
    input  logic             i_drain,
    output logic             o_ce,
    output logic             o_active
);

    logic [DIV_W-1:0] r_div_q,   w_div_d;
    logic [DIV_W-1:0] r_phase_q, w_phase_d;
    logic [DIV_W-1:0] r_cnt_q,   w_cnt_d;
    logic             r_active_q, w_active_d;
    logic             w_strobe;

    assign w_strobe = r_active_q && (r_cnt_q == '0) && (i_run || i_drain);
    assign o_ce     = w_strobe;
    assign o_active = r_active_q;

    always_comb begin
        w_div_d    = r_div_q;
        w_phase_d  = r_phase_q;
        w_cnt_d    = r_cnt_q;
        w_active_d = r_active_q;
        if (i_cfg_we) begin
            w_div_d   = i_cfg_div;
            w_phase_d = i_cfg_phase;
        end
        if (i_load) begin
            if (r_div_q != '0) begin
                w_cnt_d    = DIV_W'(clamp_phase(32'(r_phase_q), 32'(r_div_q)));
                w_active_d = 1'b1;
            end else begin
                w_cnt_d    = '0;
                w_active_d = 1'b0;
            end
        end else if ((i_run || i_drain) && r_active_q) begin
            // A draining channel retires on the strobe that completes its period.
            if (w_strobe) begin
                w_cnt_d = r_div_q - DIV_W'(1);
                if (i_drain) begin
                    w_active_d = 1'b0;
                end
            end else begin
                w_cnt_d = r_cnt_q - DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_q    <= '0;
            r_phase_q  <= '0;
            r_cnt_q    <= '0;
            r_active_q <= 1'b0;
        end else begin
            r_div_q    <= w_div_d;
            r_phase_q  <= w_phase_d;
            r_cnt_q    <= w_cnt_d;
            r_active_q <= w_active_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sim_clock_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : sim_clock_scheduler
// Brief    : Per-channel clock-enable strobes with sequenced start/drain/stop.
// Revision : 1.0
// ============================================================================
module sim_clock_scheduler
    import sim_clock_scheduler_pkg::*;
#(
    parameter int NUM_CLK = 4,
    parameter int DIV_W   = c_DIV_W_DEFAULT,
    parameter int IDX_W   = (NUM_CLK > 1) ? $clog2(NUM_CLK) : 1
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [IDX_W-1:0]   cfg_index,
    input  logic [DIV_W-1:0]   cfg_div,
    input  logic [DIV_W-1:0]   cfg_phase,
    input  logic               start,
    input  logic               stop,
    output logic [NUM_CLK-1:0] ce,
    output logic               busy,
    output logic               done
);

    state_e             r_state_q, w_state_d;
    logic [NUM_CLK-1:0] w_ce;
    logic [NUM_CLK-1:0] w_active;
    logic               w_cfg_fire;
    logic               w_load;
    logic               w_run;
    logic               w_drain;
    logic               w_drain_done;

    assign w_cfg_fire = cfg_valid && (r_state_q == S_IDLE);
    // Channels strobing this cycle in DRAIN are already counted as retired.
    assign w_drain_done = ~|(w_active & ~w_ce);
    assign ce = w_ce;

    generate
        for (genvar i = 0; i < NUM_CLK; i++) begin : g_chan
            sim_clock_sched_chan #(
                .DIV_W (DIV_W)
            ) u_chan (
                .clk         (sys_clk),
                .rst         (sys_rst),
                .i_cfg_we    (w_cfg_fire && (cfg_index == IDX_W'(i))),
                .i_cfg_div   (cfg_div),
                .i_cfg_phase (cfg_phase),
                .i_load      (w_load),
                .i_run       (w_run),
                .i_drain     (w_drain),
                .o_ce        (w_ce[i]),
                .o_active    (w_active[i])
            );
        end
    endgenerate

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state_q <= S_IDLE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            S_IDLE:  if (start) w_state_d = S_ALIGN;
            S_ALIGN: w_state_d = S_RUN;
            S_RUN:   if (stop || ~|w_active) w_state_d = S_DRAIN;
            S_DRAIN: if (w_drain_done) w_state_d = S_IDLE;
            default: w_state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cfg_ready = (r_state_q == S_IDLE);
        busy      = (r_state_q != S_IDLE);
        w_load    = (r_state_q == S_ALIGN);
        w_run     = (r_state_q == S_RUN);
        w_drain   = (r_state_q == S_DRAIN);
        done      = (r_state_q == S_DRAIN) && w_drain_done;
    end

endmodule
`default_nettype wire

// File: tb/tb_sim_clock_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_sim_clock_scheduler
// Brief    : Scoreboard bench for sim_clock_scheduler (4 channels, 16-bit).
// Revision : 1.0
// ============================================================================
module tb_sim_clock_scheduler;

    typedef struct packed {
        logic [3:0] ce;
        logic       busy;
        logic       done;
        logic       rdy;
    } exp_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [1:0]  cfg_index = '0;
    logic [15:0] cfg_div = '0;
    logic [15:0] cfg_phase = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [3:0]  ce;
    logic        busy;
    logic        done;

    exp_t sb[$];
    int   m_div[4];
    int   m_ph[4];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    sim_clock_scheduler dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_index (cfg_index),
        .cfg_div   (cfg_div),
        .cfg_phase (cfg_phase),
        .start     (start),
        .stop      (stop),
        .ce        (ce),
        .busy      (busy),
        .done      (done)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d: got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit strobe_at(input int rel, input int dv, input int ph);
        int cp;
        if (dv == 0) return 1'b0;
        cp = (ph < dv - 1) ? ph : dv - 1;
        return (rel >= cp) && (((rel - cp) % dv) == 0);
    endfunction

    function automatic logic [3:0] ce_at(input int rel);
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = strobe_at(rel, m_div[i], m_ph[i]);
        return v;
    endfunction

    task automatic push_exp(input logic [3:0] c, input logic b, input logic d, input logic r);
        exp_t e;
        e.ce = c; e.busy = b; e.done = d; e.rdy = r;
        sb.push_back(e);
    endtask

    task automatic observe(input string tag);
        exp_t e;
        @(posedge sys_clk);
        #1;
        cyc++;
        if (sb.size() == 0) begin
            check_eq({tag, ".sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            check_eq({tag, ".ce"},   int'(ce),        int'(e.ce));
            check_eq({tag, ".busy"}, int'(busy),      int'(e.busy));
            check_eq({tag, ".done"}, int'(done),      int'(e.done));
            check_eq({tag, ".rdy"},  int'(cfg_ready), int'(e.rdy));
        end
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        start = 1'b0; stop = 1'b0; cfg_valid = 1'b0;
        @(posedge sys_clk); #1;
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin m_div[i] = 0; m_ph[i] = 0; end
        push_exp(4'b0, 1'b0, 1'b0, 1'b1);
        observe("reset");
    endtask

    task automatic cfg_write(input logic [1:0] idx, input logic [15:0] dv, input logic [15:0] ph);
        cfg_valid = 1'b1; cfg_index = idx; cfg_div = dv; cfg_phase = ph;
        push_exp(4'b0, 1'b0, 1'b0, 1'b1);
        observe("cfg");
        cfg_valid = 1'b0;
        m_div[idx] = int'(dv);
        m_ph[idx]  = int'(ph);
    endtask

    // Expected trace: ALIGN, run_len RUN cycles (stop in the last), drain, IDLE.
    task automatic do_run(input string tag, input int run_len, input bit inject);
        bit   any_en;
        int   s[4];
        int   last;
        int   n;
        any_en = 1'b0;
        for (int i = 0; i < 4; i++) if (m_div[i] != 0) any_en = 1'b1;
        push_exp(4'b0, 1'b1, 1'b0, 1'b0);
        if (!any_en) begin
            push_exp(4'b0, 1'b1, 1'b0, 1'b0);
            push_exp(4'b0, 1'b1, 1'b1, 1'b0);
        end else begin
            for (int rel = 0; rel < run_len; rel++) push_exp(ce_at(rel), 1'b1, 1'b0, 1'b0);
            last = run_len;
            for (int i = 0; i < 4; i++) begin
                s[i] = -1;
                if (m_div[i] != 0) begin
                    s[i] = run_len;
                    while (!strobe_at(s[i], m_div[i], m_ph[i])) s[i]++;
                    if (s[i] > last) last = s[i];
                end
            end
            for (int rel = run_len; rel <= last; rel++) begin
                logic [3:0] cv;
                for (int i = 0; i < 4; i++) cv[i] = (rel == s[i]);
                push_exp(cv, 1'b1, rel == last, 1'b0);
            end
        end
        push_exp(4'b0, 1'b0, 1'b0, 1'b1);
        n = sb.size();
        start = 1'b1;
        for (int c = 0; c < n; c++) begin
            observe(tag);
            start = 1'b0;
            stop  = any_en && (c == run_len);
            if (inject && c == 2) begin
                cfg_valid = 1'b1; cfg_index = 2'd0; cfg_div = 16'd9; cfg_phase = 16'd0;
            end else begin
                cfg_valid = 1'b0;
            end
        end
        stop = 1'b0;
        cfg_valid = 1'b0;
    endtask

    initial begin
        do_reset();

        // Mixed ratios, clamped phase, one disabled channel.
        cfg_write(2'd0, 16'd1, 16'd0);
        cfg_write(2'd1, 16'd4, 16'd1);
        cfg_write(2'd2, 16'd3, 16'd7);
        do_run("mix", 12, 1'b0);

        // Write attempted during RUN must be ignored.
        do_run("run_cfg", 8, 1'b1);

        // Same write in IDLE changes the ch0 period.
        cfg_write(2'd0, 16'd9, 16'd0);
        do_run("div9", 20, 1'b0);

        // Stop one cycle after a ch1 strobe; one more strobe drains it.
        do_reset();
        cfg_write(2'd1, 16'd4, 16'd0);
        do_run("drain", 6, 1'b0);

        // Everything disabled.
        do_reset();
        do_run("all_off", 1, 1'b0);

        // Reset mid-RUN aborts and clears configuration.
        cfg_write(2'd0, 16'd2, 16'd0);
        push_exp(4'b0, 1'b1, 1'b0, 1'b0);
        start = 1'b1;
        observe("abort_align");
        start = 1'b0;
        push_exp(4'b0001, 1'b1, 1'b0, 1'b0);
        observe("abort_run");
        sys_rst = 1'b1;
        push_exp(4'b0, 1'b0, 1'b0, 1'b1);
        observe("abort_rst");
        sys_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin m_div[i] = 0; m_ph[i] = 0; end
        push_exp(4'b0, 1'b0, 1'b0, 1'b1);
        observe("abort_idle");
        do_run("after_abort", 1, 1'b0);

        check_eq("sb_leftover", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
